rvfi_monitor_rv32imc: RTL and testbench

//  Simulation checker on the RVFI retirement bus of an out-of-order RV32IMC core (8 retire channels).

---
 rtl/rvfi_mon_pkg.sv | 77 +++++++
 rtl/rvfi_mon_chan_check.sv | 85 ++++++++
 rtl/rvfi_monitor_rv32imc.sv | 105 ++++++++++
 tb/tb_rvfi_monitor_rv32imc.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_mon_pkg.sv
// Shared types, error codes and small legality helpers for the RV32IMC
// retirement-bus monitor. Build option: RVFI_MON_RVC_EN (compressed
// instructions legal, PCs need only 2-byte alignment).
package rvfi_mon_pkg;

    localparam int NRET = 8;
    localparam int XLEN = 32;

    localparam logic [15:0] ERR_NONE  = 16'd0;
    localparam logic [15:0] ERR_ORDER = 16'd101;
    localparam logic [15:0] ERR_TRAP  = 16'd102;
    localparam logic [15:0] ERR_HALT  = 16'd103;
    localparam logic [15:0] ERR_RS1   = 16'd110;
    localparam logic [15:0] ERR_RS2   = 16'd111;
    localparam logic [15:0] ERR_RD0   = 16'd112;
    localparam logic [15:0] ERR_PC    = 16'd120;
    localparam logic [15:0] ERR_ALIGN = 16'd121;
    localparam logic [15:0] ERR_ILEN  = 16'd122;
    localparam logic [15:0] ERR_MASK  = 16'd130;

    // One retire channel, reduced to the fields the monitor checks.
    typedef struct packed {
        logic            valid;
        logic [63:0]     order;
        logic [31:0]     insn;
        logic            trap;
        logic            halt;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rs1_rdata;
        logic [XLEN-1:0] rs2_rdata;
        logic [XLEN-1:0] rd_wdata;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
        logic [3:0]      mem_rmask;
        logic [3:0]      mem_wmask;
    } rvfi_chan_t;

    // Architectural view the monitor carries from one retirement to the next.
    typedef struct packed {
        logic [63:0]               order;
        logic [XLEN-1:0]           last_pc;
        logic                      last_pc_vld;
        logic                      halted;
        logic [31:0]               reg_vld;
        logic [31:0][XLEN-1:0]     regs;
    } mon_state_t;

    // Byte masks a single naturally aligned access may legally produce.
    function automatic logic mask_ok(logic [3:0] m);
        return m inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                         4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction

    function automatic logic pc_misaligned(logic [1:0] pc_lo);
`ifdef RVFI_MON_RVC_EN
        return pc_lo[0];
`else
        return |pc_lo;
`endif
    endfunction

    // Length encoding lives in the low opcode bits; anything longer than
    // 32 bits is illegal, 16-bit forms only when compressed is enabled.
    function automatic logic insn_len_bad(logic [4:0] insn_lo);
        if (insn_lo[1:0] == 2'b11) begin
            return insn_lo[4:2] == 3'b111;
        end
`ifdef RVFI_MON_RVC_EN
        return 1'b0;
`else
        return 1'b1;
`endif
    endfunction

endpackage

// File: rtl/rvfi_mon_chan_check.sv
// Combinational checks for one retire channel. Takes the monitor state as
// left by all lower channels this cycle and hands the updated state on.
module rvfi_mon_chan_check
    import rvfi_mon_pkg::*;
(
    input  rvfi_chan_t  chan_i,
    input  mon_state_t  state_i,
    output mon_state_t  state_o,
    output logic [15:0] err_o
);

    logic e_order, e_trap, e_halt, e_rs1, e_rs2, e_rd0;
    logic e_pc, e_align, e_ilen, e_mask;

    // Upper opcode bits do not affect the length check.
    logic unused_insn;
    assign unused_insn = ^chan_i.insn[31:5];

    // Evaluate every rule and fold this retirement into the running state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (which would infer a latch).
        state_o = state_i;
        {e_order, e_trap, e_halt, e_rs1, e_rs2, e_rd0, e_pc, e_align, e_ilen, e_mask} = '0;

        if (chan_i.valid) begin
            // NOTE: blocking '=' here lets later statements see the rs1 seed and earlier updates in order.
            e_order       = chan_i.order != state_i.order;
            state_o.order = state_i.order + 64'd1;

            e_trap = chan_i.trap;
            e_halt = state_i.halted;
            if (chan_i.halt) state_o.halted = 1'b1;

            if (chan_i.rs1_addr == 5'd0) begin
                e_rs1 = chan_i.rs1_rdata != '0;
            end else if (state_o.reg_vld[chan_i.rs1_addr]) begin
                e_rs1 = chan_i.rs1_rdata != state_o.regs[chan_i.rs1_addr];
            end else begin
                state_o.regs[chan_i.rs1_addr]    = chan_i.rs1_rdata;
                state_o.reg_vld[chan_i.rs1_addr] = 1'b1;
            end

            if (chan_i.rs2_addr == 5'd0) begin
                e_rs2 = chan_i.rs2_rdata != '0;
            end else if (state_o.reg_vld[chan_i.rs2_addr]) begin
                e_rs2 = chan_i.rs2_rdata != state_o.regs[chan_i.rs2_addr];
            end else begin
                state_o.regs[chan_i.rs2_addr]    = chan_i.rs2_rdata;
                state_o.reg_vld[chan_i.rs2_addr] = 1'b1;
            end

            if (chan_i.rd_addr == 5'd0) begin
                e_rd0 = chan_i.rd_wdata != '0;
            end else begin
                state_o.regs[chan_i.rd_addr]    = chan_i.rd_wdata;
                state_o.reg_vld[chan_i.rd_addr] = 1'b1;
            end

            e_pc                = state_i.last_pc_vld && (chan_i.pc_rdata != state_i.last_pc);
            state_o.last_pc     = chan_i.pc_wdata;
            state_o.last_pc_vld = 1'b1;

            e_align = pc_misaligned(chan_i.pc_rdata[1:0]) | pc_misaligned(chan_i.pc_wdata[1:0]);
            e_ilen  = insn_len_bad(chan_i.insn[4:0]);
            e_mask  = !mask_ok(chan_i.mem_rmask) || !mask_ok(chan_i.mem_wmask) ||
                      ((chan_i.mem_rmask != '0) && (chan_i.mem_wmask != '0));
        end
    end

    // Report only the highest-priority violation of this channel.
    always_comb begin
        if      (e_order) err_o = ERR_ORDER;
        else if (e_trap)  err_o = ERR_TRAP;
        else if (e_halt)  err_o = ERR_HALT;
        else if (e_rs1)   err_o = ERR_RS1;
        else if (e_rs2)   err_o = ERR_RS2;
        else if (e_rd0)   err_o = ERR_RD0;
        else if (e_pc)    err_o = ERR_PC;
        else if (e_align) err_o = ERR_ALIGN;
        else if (e_ilen)  err_o = ERR_ILEN;
        else if (e_mask)  err_o = ERR_MASK;
        else              err_o = ERR_NONE;
    end

endmodule

// File: rtl/rvfi_monitor_rv32imc.sv
// RVFI retirement-bus checker for an 8-wide RV32IMC core. Channels are
// checked in ascending index through a chain of per-channel checkers; the
// first violation is held in errcode until reset. Build option:
// RVFI_MON_RVC_EN enables compressed instructions and 2-byte PC alignment.
module rvfi_monitor_rv32imc
    import rvfi_mon_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [64*NRET-1:0]   rvfi_order,
    input  logic [32*NRET-1:0]   rvfi_insn,
    input  logic [NRET-1:0]      rvfi_trap,
    input  logic [NRET-1:0]      rvfi_halt,
    input  logic [NRET-1:0]      rvfi_intr,
    input  logic [2*NRET-1:0]    rvfi_mode,
    input  logic [5*NRET-1:0]    rvfi_rs1_addr,
    input  logic [5*NRET-1:0]    rvfi_rs2_addr,
    input  logic [5*NRET-1:0]    rvfi_rd_addr,
    input  logic [32*NRET-1:0]   rvfi_rs1_rdata,
    input  logic [32*NRET-1:0]   rvfi_rs2_rdata,
    input  logic [32*NRET-1:0]   rvfi_rd_wdata,
    input  logic [32*NRET-1:0]   rvfi_pc_rdata,
    input  logic [32*NRET-1:0]   rvfi_pc_wdata,
    input  logic [32*NRET-1:0]   rvfi_mem_addr,
    input  logic [32*NRET-1:0]   rvfi_mem_rdata,
    input  logic [32*NRET-1:0]   rvfi_mem_wdata,
    input  logic [4*NRET-1:0]    rvfi_mem_rmask,
    input  logic [4*NRET-1:0]    rvfi_mem_wmask,
    input  logic [NRET-1:0]      rvfi_mem_extamo,
    output logic [15:0]          errcode
);

    rvfi_chan_t  chan     [NRET];
    mon_state_t  chain    [NRET+1];
    logic [15:0] chan_err [NRET];
    mon_state_t  state_q, state_d;
    logic [15:0] errcode_q, first_err;

    // Fields carried on the bus but not checked by this monitor.
    logic unused_inputs;
    assign unused_inputs = ^{rvfi_intr, rvfi_mode, rvfi_mem_extamo,
                             rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata};

    // Slice the flat RVFI buses into one record per retire channel.
    always_comb begin
        for (int i = 0; i < NRET; i++) begin
            chan[i].valid     = rvfi_valid[i];
            chan[i].order     = rvfi_order[64*i +: 64];
            chan[i].insn      = rvfi_insn[32*i +: 32];
            chan[i].trap      = rvfi_trap[i];
            chan[i].halt      = rvfi_halt[i];
            chan[i].rs1_addr  = rvfi_rs1_addr[5*i +: 5];
            chan[i].rs2_addr  = rvfi_rs2_addr[5*i +: 5];
            chan[i].rd_addr   = rvfi_rd_addr[5*i +: 5];
            chan[i].rs1_rdata = rvfi_rs1_rdata[32*i +: 32];
            chan[i].rs2_rdata = rvfi_rs2_rdata[32*i +: 32];
            chan[i].rd_wdata  = rvfi_rd_wdata[32*i +: 32];
            chan[i].pc_rdata  = rvfi_pc_rdata[32*i +: 32];
            chan[i].pc_wdata  = rvfi_pc_wdata[32*i +: 32];
            chan[i].mem_rmask = rvfi_mem_rmask[4*i +: 4];
            chan[i].mem_wmask = rvfi_mem_wmask[4*i +: 4];
        end
    end

    // Channel k sees the state after channels 0..k-1, which gives in-cycle
    // forwarding and highest-channel-wins for duplicate rd writes.
    assign chain[0] = state_q;
    for (genvar g = 0; g < NRET; g++) begin : g_chk
        rvfi_mon_chan_check u_chk (
            .chan_i  (chan[g]),
            .state_i (chain[g]),
            .state_o (chain[g+1]),
            .err_o   (chan_err[g])
        );
    end
    assign state_d = chain[NRET];

    // Lowest channel with any violation supplies the cycle's error.
    always_comb begin
        first_err = ERR_NONE;
        for (int i = NRET - 1; i >= 0; i--) begin
            if (chan_err[i] != ERR_NONE) first_err = chan_err[i];
        end
    end

    // Commit the post-cycle state and latch the first error ever seen.
    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: shadow register data and last PC are guarded by valid bits, so only those bits need a reset.
            state_q.order       <= '0;
            state_q.last_pc_vld <= 1'b0;
            state_q.halted      <= 1'b0;
            state_q.reg_vld     <= '0;
            errcode_q           <= ERR_NONE;
        end else begin
            // NOTE: non-blocking '<=' so every register samples pre-edge values.
            state_q <= state_d;
            if (errcode_q == ERR_NONE) errcode_q <= first_err;
        end
    end

    assign errcode = errcode_q;

endmodule

// File: tb/tb_rvfi_monitor_rv32imc.sv
// Self-checking bench for rvfi_monitor_rv32imc: directed scenarios with
// literal expectations plus randomized legal traffic with injected faults,
// all compared against a sequential behavioural model of the rules.
`timescale 1ns/1ps
module tb_rvfi_monitor_rv32imc;

    localparam int NCH = 8;
`ifdef RVFI_MON_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif
    localparam int PC_ALIGN = RVC ? 2 : 4;

    logic                clock, reset;
    logic [NCH-1:0]      rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr, rvfi_mem_extamo;
    logic [64*NCH-1:0]   rvfi_order;
    logic [32*NCH-1:0]   rvfi_insn, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [32*NCH-1:0]   rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [2*NCH-1:0]    rvfi_mode;
    logic [5*NCH-1:0]    rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [4*NCH-1:0]    rvfi_mem_rmask, rvfi_mem_wmask;
    logic [15:0]         errcode;

    rvfi_monitor_rv32imc dut (
        .clock(clock), .reset(reset),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr), .rvfi_mode(rvfi_mode),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_mem_extamo(rvfi_mem_extamo), .errcode(errcode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        bit        v;
        bit [63:0] order;
        bit [31:0] insn;
        bit        trap, halt;
        bit [4:0]  rs1, rs2, rd;
        bit [31:0] rs1_d, rs2_d, rd_d, pc_r, pc_w;
        bit [3:0]  rm, wm;
    } ch_t;

    ch_t ch [NCH];
    bit [3:0] legal_masks [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit [31:0]       m_reg [32];
    bit              m_vld [32];
    longint unsigned m_order;
    bit [31:0]       m_pc;
    bit              m_pc_vld, m_halted;
    int              m_err;

    // Stimulus generator state (ground truth for legal traffic)
    bit [31:0]       gen_reg [32];
    longint unsigned gen_order;
    bit [31:0]       gen_pc;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: errcode=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_chans();
        for (int i = 0; i < NCH; i++) ch[i] = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < NCH; i++) begin
            rvfi_valid[i]              = ch[i].v;
            rvfi_order[64*i +: 64]     = ch[i].order;
            rvfi_insn[32*i +: 32]      = ch[i].insn;
            rvfi_trap[i]               = ch[i].trap;
            rvfi_halt[i]               = ch[i].halt;
            rvfi_rs1_addr[5*i +: 5]    = ch[i].rs1;
            rvfi_rs2_addr[5*i +: 5]    = ch[i].rs2;
            rvfi_rd_addr[5*i +: 5]     = ch[i].rd;
            rvfi_rs1_rdata[32*i +: 32] = ch[i].rs1_d;
            rvfi_rs2_rdata[32*i +: 32] = ch[i].rs2_d;
            rvfi_rd_wdata[32*i +: 32]  = ch[i].rd_d;
            rvfi_pc_rdata[32*i +: 32]  = ch[i].pc_r;
            rvfi_pc_wdata[32*i +: 32]  = ch[i].pc_w;
            rvfi_mem_rmask[4*i +: 4]   = ch[i].rm;
            rvfi_mem_wmask[4*i +: 4]   = ch[i].wm;
            rvfi_intr[i]               = 1'($urandom);
            rvfi_mem_extamo[i]         = 1'($urandom);
            rvfi_mode[2*i +: 2]        = 2'($urandom);
            rvfi_mem_addr[32*i +: 32]  = $urandom;
            rvfi_mem_rdata[32*i +: 32] = $urandom;
            rvfi_mem_wdata[32*i +: 32] = $urandom;
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_vld[r] = 1'b0;
        m_order  = 0;
        m_pc_vld = 1'b0;
        m_halted = 1'b0;
        m_err    = 0;
    endtask

    task automatic model_read(input bit [4:0] a, input bit [31:0] d, input int code, inout int e);
        if (a == 0) begin
            if (e == 0 && d != 0) e = code;
        end else if (m_vld[a]) begin
            if (e == 0 && d != m_reg[a]) e = code;
        end else begin
            m_reg[a] = d;
            m_vld[a] = 1'b1;
        end
    endtask

    function automatic bit mask_legal(bit [3:0] m);
        for (int j = 0; j < 8; j++) if (legal_masks[j] == m) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit len_legal(bit [31:0] insn);
        if (insn[1:0] == 2'b11) return insn[4:2] != 3'b111;
        return RVC;
    endfunction

    // Walk valid channels in order, applying the rules one retirement at a time.
    task automatic model_step();
        int first = 0;
        for (int i = 0; i < NCH; i++) begin
            int e = 0;
            if (!ch[i].v) continue;
            if (ch[i].order != m_order) e = 101;
            m_order++;
            if (e == 0 && ch[i].trap) e = 102;
            if (e == 0 && m_halted) e = 103;
            if (ch[i].halt) m_halted = 1'b1;
            model_read(ch[i].rs1, ch[i].rs1_d, 110, e);
            model_read(ch[i].rs2, ch[i].rs2_d, 111, e);
            if (ch[i].rd == 0) begin
                if (e == 0 && ch[i].rd_d != 0) e = 112;
            end else begin
                m_reg[ch[i].rd] = ch[i].rd_d;
                m_vld[ch[i].rd] = 1'b1;
            end
            if (e == 0 && m_pc_vld && ch[i].pc_r != m_pc) e = 120;
            m_pc     = ch[i].pc_w;
            m_pc_vld = 1'b1;
            if (e == 0 && ((ch[i].pc_r % PC_ALIGN) != 0 || (ch[i].pc_w % PC_ALIGN) != 0)) e = 121;
            if (e == 0 && !len_legal(ch[i].insn)) e = 122;
            if (e == 0 && (!mask_legal(ch[i].rm) || !mask_legal(ch[i].wm) || (ch[i].rm != 0 && ch[i].wm != 0))) e = 130;
            if (first == 0) first = e;
        end
        if (m_err == 0) m_err = first;
    endtask

    task automatic step(input string tag);
        drive();
        @(posedge clock);
        model_step();
        #1;
        check(tag, errcode, 16'(m_err));
    endtask

    // One reset edge with junk on the bus; the monitor must ignore it.
    task automatic do_reset();
        for (int i = 0; i < NCH; i++) ch[i] = ch_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        drive();
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        check("reset", errcode, 16'd0);
        clear_chans();
    endtask

    task automatic set_ch(input int i, input longint unsigned ord, input bit [31:0] pc);
        ch[i]       = '0;
        ch[i].v     = 1'b1;
        ch[i].order = ord;
        ch[i].insn  = 32'h0050_0093;
        ch[i].pc_r  = pc;
        ch[i].pc_w  = pc + 32'd4;
    endtask

    task automatic gen_chan(input int i);
        ch[i]       = '0;
        ch[i].v     = 1'b1;
        ch[i].order = gen_order;
        gen_order++;
        ch[i].insn  = $urandom;
        ch[i].insn[1:0] = 2'b11;
        if (ch[i].insn[4:2] == 3'b111) ch[i].insn[4:2] = 3'b100;
        ch[i].pc_r  = gen_pc;
        ch[i].pc_w  = ($urandom_range(0, 3) == 0) ? ($urandom & ~32'h3) : gen_pc + 32'd4;
        gen_pc      = ch[i].pc_w;
        ch[i].rs1   = 5'($urandom);
        ch[i].rs1_d = (ch[i].rs1 == 0) ? 32'd0 : gen_reg[ch[i].rs1];
        ch[i].rs2   = 5'($urandom);
        ch[i].rs2_d = (ch[i].rs2 == 0) ? 32'd0 : gen_reg[ch[i].rs2];
        ch[i].rd    = 5'($urandom);
        ch[i].rd_d  = (ch[i].rd == 0) ? 32'd0 : $urandom;
        if (ch[i].rd != 0) gen_reg[ch[i].rd] = ch[i].rd_d;
        if ($urandom_range(0, 1) == 0) ch[i].rm = legal_masks[$urandom_range(0, 7)];
        else                           ch[i].wm = legal_masks[$urandom_range(0, 7)];
    endtask

    task automatic corrupt(input int k);
        case ($urandom_range(0, 9))
            0: ch[k].order += 64'($urandom_range(1, 5));
            1: ch[k].trap = 1'b1;
            2: ch[k].halt = 1'b1;
            3: ch[k].rs1_d ^= 32'h1;
            4: ch[k].rs2_d ^= 32'h8000_0000;
            5: begin ch[k].rd = 5'd0; ch[k].rd_d = $urandom | 32'h1; end
            6: ch[k].pc_r += 32'd4;
            7: ch[k].pc_w[0] = 1'b1;
            8: ch[k].insn[1:0] = 2'b01;
            default: begin ch[k].rm = 4'b0101; ch[k].wm = 4'b0001; end
        endcase
    endtask

    task automatic gen_cycle(input bit inject);
        bit [NCH-1:0] vmask;
        int k;
        vmask = NCH'($urandom);
        k = $urandom_range(0, NCH - 1);
        if (inject) vmask[k] = 1'b1;
        clear_chans();
        for (int i = 0; i < NCH; i++) if (vmask[i]) gen_chan(i);
        if (inject) corrupt(k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        clear_chans();
        drive();
        model_reset();

        // Clean in-order stream: addi x1 <- 5 three times, sequential PCs.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            clear_chans();
            set_ch(0, k, 32'(4 * k));
            ch[0].rd   = 5'd1;
            ch[0].rd_d = 32'd5;
            step("seq");
            check("seq_clean", errcode, 16'd0);
        end

        // Order gap within one cycle, then held through a clean cycle.
        do_reset();
        set_ch(0, 0, 32'h0);
        set_ch(1, 2, 32'h4);
        step("order_gap_model");
        check("order_gap", errcode, 16'd101);
        clear_chans();
        step("idle_model");
        check("order_sticky", errcode, 16'd101);

        // In-cycle forwarding: ch1 must see ch0's write of x3.
        do_reset();
        set_ch(0, 0, 32'h0);
        ch[0].rd = 5'd3; ch[0].rd_d = 32'h1234;
        set_ch(1, 1, 32'h4);
        ch[1].rs1 = 5'd3; ch[1].rs1_d = 32'h1235;
        step("fwd_model");
        check("fwd_rs1", errcode, 16'd110);

        // PC discontinuity across cycles.
        do_reset();
        set_ch(0, 0, 32'hfc);
        step("pc_first");
        check("pc_first_clean", errcode, 16'd0);
        clear_chans();
        set_ch(0, 1, 32'h104);
        step("pc_model");
        check("pc_cont", errcode, 16'd120);

        // Compressed instruction at a halfword PC, then at a word PC.
        do_reset();
        set_ch(0, 0, 32'h2);
        ch[0].insn = 32'h0000_4501;
        step("rvc_pc2_model");
        check("rvc_pc2", errcode, 16'(RVC ? 0 : 121));
        do_reset();
        set_ch(0, 0, 32'h0);
        ch[0].insn = 32'h0000_4501;
        step("rvc_pc0_model");
        check("rvc_pc0", errcode, 16'(RVC ? 0 : 122));

        // Retirement after halt in the same cycle, then reset restarts order.
        do_reset();
        set_ch(0, 0, 32'h0);
        ch[0].halt = 1'b1;
        set_ch(3, 1, 32'h4);
        step("halt_model");
        check("halt_same_cycle", errcode, 16'd103);
        do_reset();
        set_ch(0, 0, 32'h40);
        step("restart_model");
        check("order_restart", errcode, 16'd0);

        // Randomized legal traffic with one injected fault per trial.
        for (int t = 0; t < 60; t++) begin
            do_reset();
            gen_order = 0;
            gen_pc    = $urandom & ~32'h3;
            for (int r = 0; r < 32; r++) gen_reg[r] = $urandom;
            for (int c = 0; c < 8; c++) begin
                gen_cycle(c == 5);
                step("rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
